// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU op sequencer:
//   - opcode encodings OP_WRITE..OP_RSF and OP_LAST (highest legal opcode)
//   - alu_en bit positions (bit n enables the ALU function for opcode n)
//   - FSM state encodings S_IDLE / S_ISSUE / S_WB
//   - small decode helpers used by the sequencer
// -----------------------------------------------------------------------------
package alu_seq_pkg;

  localparam int OP_W = 4;
  localparam int EN_W = 13;

  localparam logic [OP_W-1:0] OP_WRITE = 4'd0;
  localparam logic [OP_W-1:0] OP_READ  = 4'd1;
  localparam logic [OP_W-1:0] OP_COPY  = 4'd2;
  localparam logic [OP_W-1:0] OP_NOT   = 4'd3;
  localparam logic [OP_W-1:0] OP_AND   = 4'd4;
  localparam logic [OP_W-1:0] OP_OR    = 4'd5;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_NAND  = 4'd7;
  localparam logic [OP_W-1:0] OP_NOR   = 4'd8;
  localparam logic [OP_W-1:0] OP_ADD   = 4'd9;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd10;
  localparam logic [OP_W-1:0] OP_LSF   = 4'd11;
  localparam logic [OP_W-1:0] OP_RSF   = 4'd12;
  localparam logic [OP_W-1:0] OP_LAST  = 4'd12;

  localparam int EN_WRITE = 0;
  localparam int EN_READ  = 1;
  localparam int EN_COPY  = 2;
  localparam int EN_NOT   = 3;
  localparam int EN_AND   = 4;
  localparam int EN_OR    = 5;
  localparam int EN_XOR   = 6;
  localparam int EN_NAND  = 7;
  localparam int EN_NOR   = 8;
  localparam int EN_ADD   = 9;
  localparam int EN_SUB   = 10;
  localparam int EN_LSF   = 11;
  localparam int EN_RSF   = 12;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WB    = 2'd2;

  // Opcodes 13..15 have no ALU function behind them.
  function automatic logic opcode_legal(input logic [OP_W-1:0] op);
    return (op <= OP_LAST);
  endfunction

  // Only ADD and SUB produce a meaningful overflow.
  function automatic logic opcode_arith(input logic [OP_W-1:0] op);
    return ((op == OP_ADD) || (op == OP_SUB));
  endfunction

  // One-hot ALU enable for an opcode; all-zero for illegal opcodes.
  function automatic logic [EN_W-1:0] opcode_onehot(input logic [OP_W-1:0] op);
    logic [EN_W-1:0] en;
    en = {EN_W{1'b0}};
    case (op)
      OP_WRITE: en[EN_WRITE] = 1'b1;
      OP_READ:  en[EN_READ]  = 1'b1;
      OP_COPY:  en[EN_COPY]  = 1'b1;
      OP_NOT:   en[EN_NOT]   = 1'b1;
      OP_AND:   en[EN_AND]   = 1'b1;
      OP_OR:    en[EN_OR]    = 1'b1;
      OP_XOR:   en[EN_XOR]   = 1'b1;
      OP_NAND:  en[EN_NAND]  = 1'b1;
      OP_NOR:   en[EN_NOR]   = 1'b1;
      OP_ADD:   en[EN_ADD]   = 1'b1;
      OP_SUB:   en[EN_SUB]   = 1'b1;
      OP_LSF:   en[EN_LSF]   = 1'b1;
      OP_RSF:   en[EN_RSF]   = 1'b1;
      default:  en = {EN_W{1'b0}};
    endcase
    return en;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// -----------------------------------------------------------------------------
// alu_seq_regfile
// NREG x DATA_W register file with two combinational read ports and one
// synchronous write port. Contents clear asynchronously on rst_n low.
// Ports:
//   clk, rst_n           clock / async active-low clear
//   wr_en, wr_addr, wr_data   write port (rising edge)
//   rd_addr_a/rd_data_a  read port A (combinational)
//   rd_addr_b/rd_data_b  read port B (combinational)
// -----------------------------------------------------------------------------
module alu_seq_regfile #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b
);

  logic [DATA_W-1:0] mem_r [NREG];

  // Storage: async clear, single synchronous write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem_r[rd_addr_a];
  assign rd_data_b = mem_r[rd_addr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Feeds a one-hot-enable ALU from a valid/ready instruction stream and owns a
// small register file. Each instruction runs IDLE -> ISSUE -> WB: operands and
// the one-hot enable are driven for the single ISSUE cycle, the ALU result and
// overflow are captured at the end of ISSUE, and WB retires the instruction
// (done pulse, register write or READ capture, overflow flag update).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr_ready    instruction handshake (ready only in IDLE)
//   instr_opcode/rd/rs/imm     instruction fields
//   alu_en, alu_rd1, alu_rd2   ALU drive (non-zero only during ISSUE)
//   alu_result, alu_overflow   ALU response (combinational in the ALU)
//   done, err                  retire pulse; err marks an illegal opcode
//   read_data                  result of the most recent READ
//   ovf_flag                   overflow of the most recent ADD/SUB
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_opcode,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [EN_W-1:0]   alu_en,
  output logic [DATA_W-1:0] alu_rd1,
  output logic [DATA_W-1:0] alu_rd2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] read_data,
  output logic              ovf_flag
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              ready_r;
  logic              accept_s;
  logic [OP_W-1:0]   op_r;
  logic [ADDR_W-1:0] rd_r;
  logic [EN_W-1:0]   alu_en_r;
  logic [DATA_W-1:0] alu_rd1_r;
  logic [DATA_W-1:0] alu_rd2_r;
  logic [DATA_W-1:0] rd1_nxt_s;
  logic [DATA_W-1:0] rd2_nxt_s;
  logic [DATA_W-1:0] rf_rd_a_s;
  logic [DATA_W-1:0] rf_rd_b_s;
  logic              rf_we_s;
  logic [DATA_W-1:0] result_r;
  logic              ovf_cap_r;
  logic              done_r;
  logic              err_r;
  logic [DATA_W-1:0] read_data_r;
  logic              ovf_flag_r;

  // ready_r also holds off acceptance for the first cycle after reset release.
  assign accept_s = (state_r == S_IDLE) && ready_r && instr_valid;

  // Register file: operands are read with the incoming rd/rs so they can be
  // registered on the accept edge; the write port is used only in WB.
  alu_seq_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (rf_we_s),
    .wr_addr   (rd_r),
    .wr_data   (result_r),
    .rd_addr_a (instr_rd),
    .rd_data_a (rf_rd_a_s),
    .rd_addr_b (instr_rs),
    .rd_data_b (rf_rd_b_s)
  );

  // Next-state logic for the three-phase instruction sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_ISSUE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: state_nxt_s = S_WB;
      S_WB:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Operand selection for the instruction being accepted.
  always_comb begin
    rd1_nxt_s = rf_rd_a_s;
    rd2_nxt_s = rf_rd_b_s;
    case (instr_opcode)
      OP_WRITE: begin
        rd1_nxt_s = instr_imm;
        rd2_nxt_s = {DATA_W{1'b0}};
      end
      OP_COPY: begin
        rd1_nxt_s = rf_rd_b_s;
        rd2_nxt_s = {DATA_W{1'b0}};
      end
      default: begin
        rd1_nxt_s = rf_rd_a_s;
        rd2_nxt_s = rf_rd_b_s;
      end
    endcase
  end

  // Register-file write enable: every legal opcode except READ writes R[rd].
  always_comb begin
    if ((state_r == S_WB) && opcode_legal(op_r) && (op_r != OP_READ)) begin
      rf_we_s = 1'b1;
    end else begin
      rf_we_s = 1'b0;
    end
  end

  // FSM state and the registered ready output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == S_IDLE);
    end
  end

  // Instruction latch and ALU drive; the drive registers are loaded only on
  // the accept edge, so they are non-zero for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= OP_WRITE;
      rd_r      <= {ADDR_W{1'b0}};
      alu_en_r  <= {EN_W{1'b0}};
      alu_rd1_r <= {DATA_W{1'b0}};
      alu_rd2_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      op_r      <= instr_opcode;
      rd_r      <= instr_rd;
      alu_en_r  <= opcode_onehot(instr_opcode);
      alu_rd1_r <= rd1_nxt_s;
      alu_rd2_r <= rd2_nxt_s;
    end else begin
      alu_en_r  <= {EN_W{1'b0}};
      alu_rd1_r <= {DATA_W{1'b0}};
      alu_rd2_r <= {DATA_W{1'b0}};
    end
  end

  // Capture the ALU response at the end of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r  <= {DATA_W{1'b0}};
      ovf_cap_r <= 1'b0;
    end else if (state_r == S_ISSUE) begin
      result_r  <= alu_result;
      ovf_cap_r <= alu_overflow;
    end
  end

  // Retire pulses, high for the whole WB cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= (state_r == S_ISSUE);
      err_r  <= (state_r == S_ISSUE) && !opcode_legal(op_r);
    end
  end

  // READ result and overflow flag updates at the end of WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_r <= {DATA_W{1'b0}};
      ovf_flag_r  <= 1'b0;
    end else if (state_r == S_WB) begin
      if (op_r == OP_READ) begin
        read_data_r <= result_r;
      end
      if (opcode_arith(op_r)) begin
        ovf_flag_r <= ovf_cap_r;
      end
    end
  end

  assign instr_ready = ready_r;
  assign alu_en      = alu_en_r;
  assign alu_rd1     = alu_rd1_r;
  assign alu_rd2     = alu_rd2_r;
  assign done        = done_r;
  assign err         = err_r;
  assign read_data   = read_data_r;
  assign ovf_flag    = ovf_flag_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench: a behavioural ALU answers the DUT's enables, a register-file
// model predicts every instruction, and predictions are queued at issue and
// popped at retire.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_opcode;
  logic [1:0]  instr_rd;
  logic [1:0]  instr_rs;
  logic [3:0]  instr_imm;
  logic [12:0] alu_en;
  logic [3:0]  alu_rd1;
  logic [3:0]  alu_rd2;
  logic [3:0]  alu_result;
  logic        alu_overflow;
  logic        done;
  logic        err;
  logic [3:0]  read_data;
  logic        ovf_flag;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [1:0]  rd;
    logic [12:0] en;
    logic [3:0]  rd1;
    logic [3:0]  rd2;
    logic [3:0]  res;
    logic        ovf;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_reg [4];
  logic [3:0] m_read;
  logic       m_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_W(4), .NREG(4), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_rd     (instr_rd),
    .instr_rs     (instr_rs),
    .instr_imm    (instr_imm),
    .alu_en       (alu_en),
    .alu_rd1      (alu_rd1),
    .alu_rd2      (alu_rd2),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .done         (done),
    .err          (err),
    .read_data    (read_data),
    .ovf_flag     (ovf_flag)
  );

  // Behavioural ALU: {overflow, result}; signed overflow for ADD/SUB.
  function automatic logic [4:0] alu_ref(input logic [12:0] en, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    logic       o;
    r = 4'h0;
    o = 1'b0;
    case (en)
      13'h0001, 13'h0002, 13'h0004: r = a;
      13'h0008: r = ~a;
      13'h0010: r = a & b;
      13'h0020: r = a | b;
      13'h0040: r = a ^ b;
      13'h0080: r = ~(a & b);
      13'h0100: r = ~(a | b);
      13'h0200: begin r = a + b; o = (a[3] == b[3]) && (r[3] != a[3]); end
      13'h0400: begin r = a - b; o = (a[3] != b[3]) && (r[3] != a[3]); end
      13'h0800: r = a << 1;
      13'h1000: r = a >> 1;
      default: begin r = 4'h0; o = 1'b0; end
    endcase
    return {o, r};
  endfunction

  always_comb {alu_overflow, alu_result} = alu_ref(alu_en, alu_rd1, alu_rd2);

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
    exp_t e;
    e.op  = op;
    e.rd  = rd;
    e.err = (op > 4'd12);
    e.en  = e.err ? 13'h0000 : (13'h0001 << op);
    case (op)
      4'd0:    begin e.rd1 = imm;       e.rd2 = 4'h0;      end
      4'd2:    begin e.rd1 = m_reg[rs]; e.rd2 = 4'h0;      end
      default: begin e.rd1 = m_reg[rd]; e.rd2 = m_reg[rs]; end
    endcase
    {e.ovf, e.res} = alu_ref(e.en, e.rd1, e.rd2);
    return e;
  endfunction

  task automatic retire(input exp_t e);
    if (!e.err) begin
      if (e.op == 4'd1) m_read = e.res;
      else              m_reg[e.rd] = e.res;
      if (e.op == 4'd9 || e.op == 4'd10) m_ovf = e.ovf;
    end
  endtask

  // Issue one instruction starting at a negedge; returns at the IDLE negedge
  // after retire. With hold=1 instr_valid stays high throughout.
  task automatic run_op(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [3:0] imm, input bit hold);
    exp_t e;
    int   waits;
    waits = 0;
    while (instr_ready !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    chk("ready_wait", instr_ready, 1);
    instr_opcode = op;
    instr_rd     = rd;
    instr_rs     = rs;
    instr_imm    = imm;
    instr_valid  = 1'b1;
    sb_q.push_back(predict(op, rd, rs, imm));
    @(posedge clk);
    @(negedge clk);
    e = sb_q[0];
    chk("issue_en", alu_en, e.en);
    chk("issue_rd1", alu_rd1, e.rd1);
    chk("issue_rd2", alu_rd2, e.rd2);
    chk("issue_ready", instr_ready, 0);
    chk("issue_done", done, 0);
    if (!hold) instr_valid = 1'b0;
    @(negedge clk);
    e = sb_q.pop_front();
    chk("wb_done", done, 1);
    chk("wb_err", err, e.err);
    chk("wb_en", alu_en, 0);
    chk("wb_rd1", alu_rd1, 0);
    chk("wb_ready", instr_ready, 0);
    retire(e);
    @(negedge clk);
    chk("idle_ready", instr_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_read_data", read_data, m_read);
    chk("idle_ovf", ovf_flag, m_ovf);
  endtask

  initial begin
    int d0;
    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = 4'h0;
    instr_rd     = 2'd0;
    instr_rs     = 2'd0;
    instr_imm    = 4'h0;
    for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
    m_read = 4'h0;
    m_ovf  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_rd1", alu_rd1, 0);
    chk("rst_rd2", alu_rd2, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_read_data", read_data, 0);
    chk("rst_ovf", ovf_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", instr_ready, 1);

    // T1: WRITE then READ back
    run_op(OP_WRITE, 2'd1, 2'd0, 4'hA, 1'b0);
    run_op(OP_READ, 2'd1, 2'd1, 4'h0, 1'b0);
    chk("t1_read_data", read_data, 4'hA);

    // T2: 7 + 1 signed-overflows to 8
    run_op(OP_WRITE, 2'd0, 2'd0, 4'h7, 1'b0);
    run_op(OP_WRITE, 2'd1, 2'd0, 4'h1, 1'b0);
    run_op(OP_ADD, 2'd0, 2'd1, 4'h0, 1'b0);
    chk("t2_ovf", ovf_flag, 1);
    run_op(OP_READ, 2'd0, 2'd0, 4'h0, 1'b0);
    chk("t2_r0", read_data, 4'h8);

    // T4: illegal opcode leaves state alone
    run_op(4'd14, 2'd0, 2'd1, 4'h3, 1'b0);
    chk("t4_ovf_kept", ovf_flag, 1);
    run_op(OP_READ, 2'd0, 2'd0, 4'h0, 1'b0);
    chk("t4_r0_kept", read_data, 4'h8);

    // T6: COPY R3 -> R2
    run_op(OP_WRITE, 2'd3, 2'd0, 4'h5, 1'b0);
    run_op(OP_COPY, 2'd2, 2'd3, 4'h0, 1'b0);
    chk("t6_ovf_kept", ovf_flag, 1);
    run_op(OP_READ, 2'd2, 2'd2, 4'h0, 1'b0);
    chk("t6_r2", read_data, 4'h5);

    // ADD without overflow clears the flag; rd == rs
    run_op(OP_ADD, 2'd1, 2'd1, 4'h0, 1'b0);
    chk("add_no_ovf", ovf_flag, 0);

    // T3: back-to-back with instr_valid held high
    d0 = done_cnt;
    run_op(OP_AND,  2'd2, 2'd3, 4'h0, 1'b1);
    run_op(OP_OR,   2'd0, 2'd1, 4'h0, 1'b1);
    run_op(OP_XOR,  2'd2, 2'd0, 4'h0, 1'b1);
    run_op(OP_NAND, 2'd3, 2'd1, 4'h0, 1'b1);
    run_op(OP_NOR,  2'd1, 2'd2, 4'h0, 1'b1);
    run_op(OP_NOT,  2'd0, 2'd0, 4'h0, 1'b1);
    run_op(OP_SUB,  2'd1, 2'd0, 4'h0, 1'b1);
    run_op(OP_LSF,  2'd3, 2'd0, 4'h0, 1'b1);
    run_op(OP_RSF,  2'd2, 2'd2, 4'h0, 1'b1);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t3_done_pulses", done_cnt - d0, 9);
    for (int i = 0; i < 4; i++) run_op(OP_READ, i[1:0], 2'd0, 4'h0, 1'b0);

    // T5: reset during ISSUE of ADD
    run_op(OP_WRITE, 2'd0, 2'd0, 4'hC, 1'b0);
    instr_opcode = OP_ADD;
    instr_rd     = 2'd0;
    instr_rs     = 2'd1;
    instr_valid  = 1'b1;
    sb_q.push_back(predict(OP_ADD, 2'd0, 2'd1, 4'h0));
    @(posedge clk);
    @(negedge clk);
    chk("t5_issue_en", alu_en, 13'h0200);
    rst_n = 1'b0;
    #1;
    chk("t5_en_drop", alu_en, 0);
    chk("t5_rd1_drop", alu_rd1, 0);
    chk("t5_no_done", done, 0);
    sb_q.delete();
    for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
    m_read      = 4'h0;
    m_ovf       = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_done_late", done, 0);
    chk("t5_no_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready_after", instr_ready, 1);
    chk("t5_read_data_clr", read_data, 0);
    run_op(OP_READ, 2'd0, 2'd0, 4'h0, 1'b0);
    chk("t5_r0_cleared", read_data, 4'h0);
    run_op(OP_READ, 2'd3, 2'd0, 4'h0, 1'b0);
    chk("t5_r3_cleared", read_data, 4'h0);
    chk("t5_ovf_cleared", ovf_flag, 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
